// File: rtl/mem_access_unit.sv
// Load/store initiator driving a word-only data memory with 1-cycle read latency.
// Optional request checking (alignment, range) is enabled by defining MEM_ACCESS_ERR_EN.
module mem_access_unit #(
   parameter int unsigned MEM_SIZE = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_write_en,
   output logic [31:0] mem_write_addr,
   output logic [31:0] mem_write_data,
   output logic [31:0] mem_read_addr,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [2:0] {
      IDLE,
      LD_RD,
      LD_RESP,
      ST_RD,
      ST_WR
`ifdef MEM_ACCESS_ERR_EN
      , ERR
`endif
   } state_t;

   state_t      state, next_state;
   logic [31:0] addr_q, wdata_q;
   logic [1:0]  size_q;
   logic        sgn_q, wr_q;
   logic [31:0] word_addr, load_data, store_data;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

`ifdef MEM_ACCESS_ERR_EN
   logic [2:0]  nbytes;
   logic [32:0] end_addr;
   logic        reject;

   always_comb begin
      case (req_size)
         2'b00:   nbytes = 3'd1;
         2'b01:   nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
      end_addr = {1'b0, req_addr} + 33'(nbytes);
      reject   = (req_size == 2'b01 && req_addr[0])
              || (req_size[1] && req_addr[1:0] != 2'b00)
              || (end_addr > 33'(MEM_SIZE));
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         sgn_q   <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state <= next_state;
         if (state == IDLE && req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            wr_q    <= req_write;
         end
      end
   end

   assign word_addr = {addr_q[31:2], 2'b00};
   assign byte_lane = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
   assign half_lane = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

   // Misaligned halves/words fall back to the containing word's lanes.
   always_comb begin
      case (size_q)
         2'b00:   load_data = sgn_q ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
         2'b01:   load_data = sgn_q ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
         default: load_data = mem_read_data;
      endcase
   end

   always_comb begin
      store_data = mem_read_data;
      case (size_q)
         2'b00: store_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'b01: begin
            if (addr_q[1]) store_data[31:16] = wdata_q[15:0];
            else           store_data[15:0]  = wdata_q[15:0];
         end
         default: store_data = wdata_q;
      endcase
   end

   always_comb begin
      next_state     = state;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      resp_rdata     = '0;
      resp_err       = 1'b0;
      mem_write_en   = 1'b0;
      mem_write_addr = '0;
      mem_write_data = '0;
      mem_read_addr  = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
`ifdef MEM_ACCESS_ERR_EN
               if (reject)              next_state = ERR;
               else
`endif
               if (!req_write)          next_state = LD_RD;
               else if (req_size[1])    next_state = ST_WR;
               else                     next_state = ST_RD;
            end
         end
         LD_RD: begin
            mem_read_addr = word_addr;
            next_state    = LD_RESP;
         end
         LD_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = load_data;
            next_state = IDLE;
         end
         ST_RD: begin
            mem_read_addr = word_addr;
            next_state    = ST_WR;
         end
         ST_WR: begin
            mem_write_en   = wr_q;
            mem_write_addr = word_addr;
            mem_write_data = store_data;
            resp_valid     = 1'b1;
            next_state     = IDLE;
         end
`ifdef MEM_ACCESS_ERR_EN
         ERR: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            next_state = IDLE;
         end
`endif
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset and
// back-to-back sequences, then random traffic against a byte-array reference.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_write_en;
   logic [31:0] mem_write_addr, mem_write_data, mem_read_addr, mem_read_data;

   always #5 clk = ~clk;

   mem_access_unit #(.MEM_SIZE(4096)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_write_en(mem_write_en),
      .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
      .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data)
   );

   // Word memory attached to the DUT: synchronous write, registered read.
   logic [31:0] mem_words [0:2047];
   always @(posedge clk) begin
      if (mem_write_en) mem_words[mem_write_addr[12:2]] <= mem_write_data;
      mem_read_data <= mem_words[mem_read_addr[12:2]];
   end

   // Reference model: flat byte-addressed memory.
   logic [7:0] ref_bytes [0:8191];

   int errors = 0;
   int checks = 0;
   int overlap = 0;

   always @(negedge clk)
      if (mem_write_en && mem_read_addr != 32'h0) overlap++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   function automatic int unsigned nbytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit ref_reject(input logic [1:0] size, input logic [31:0] a);
`ifdef MEM_ACCESS_ERR_EN
      int unsigned n = nbytes(size);
      return (a % n != 0) || (longint'(a) + n > 4096);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn, input logic [31:0] a);
      int unsigned n = nbytes(size);
      longint unsigned base = a - (a % n);
      longint unsigned v = 0;
      for (int unsigned i = 0; i < n; i++)
         v = v + (longint'(ref_bytes[(base + i) % 8192]) << (8 * i));
      if (n < 4 && sgn && v[8*n-1])
         v = v + (64'hFFFF_FFFF - ((64'd1 << (8 * n)) - 1));
      return v[31:0];
   endfunction

   task automatic ref_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
      int unsigned n = nbytes(size);
      longint unsigned base = a - (a % n);
      for (int unsigned i = 0; i < n; i++)
         ref_bytes[(base + i) % 8192] = 8'((d >> (8 * i)) & 32'hFF);
   endtask

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_wcnt;
      logic [31:0] exp_wdat;
   } vec_t;

   task automatic run_txn(input vec_t v, input string tag);
      int          lat = 0;
      int          wcnt = 0;
      logic [31:0] rd = 32'h0, wa = 32'h0, wd = 32'h0;
      logic        er = 1'b0;
      @(negedge clk);
      check({tag, " ready_idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = v.wr; req_size = v.size;
      req_signed = v.sgn; req_addr = v.addr; req_wdata = v.wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (mem_write_en) begin wcnt++; wa = mem_write_addr; wd = mem_write_data; end
         if (resp_valid) begin lat = n; rd = resp_rdata; er = resp_err; break; end
      end
      check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
      check({tag, " rdata"}, rd, v.exp_rdata);
      check({tag, " err"}, 32'(er), 32'(v.exp_err));
      check({tag, " write_cycles"}, 32'(wcnt), 32'(v.exp_wcnt));
      if (v.exp_wcnt > 0) begin
         check({tag, " write_addr"}, wa, {v.addr[31:2], 2'b00});
         check({tag, " write_data"}, wd, v.exp_wdat);
      end
      @(negedge clk);
      check({tag, " resp_one_cycle"}, 32'(resp_valid), 32'd0);
   endtask

   function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int exp_lat, input int exp_wcnt, input logic [31:0] exp_wdat);
      vec_t v;
      v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
      v.exp_wcnt = exp_wcnt; v.exp_wdat = exp_wdat;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      vec_t rv;
      foreach (mem_words[i]) mem_words[i] = 32'h0;
      foreach (ref_bytes[i]) ref_bytes[i] = 8'h0;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      reset = 1'b0;

      #12;
      check("reset req_ready", 32'(req_ready), 32'd1);
      check("reset resp_valid", 32'(resp_valid), 32'd0);
      check("reset mem_write_en", 32'(mem_write_en), 32'd0);
      check("reset mem_read_addr", mem_read_addr, 32'h0);
      check("reset mem_write_addr", mem_write_addr, 32'h0);
      @(negedge clk) reset = 1'b1;

      //           wr    size  sgn  addr          wdata         rdata         err lat wcnt wdat
      vecs.push_back(mk(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1, 1, 32'hDEADBEEF));
      vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0));
      vecs.push_back(mk(1, 2'd2, 0, 32'h20, 32'h11223344, 32'h0,        0, 1, 1, 32'h11223344));
      vecs.push_back(mk(1, 2'd0, 0, 32'h22, 32'h000000AA, 32'h0,        0, 2, 1, 32'h11AA3344));
      vecs.push_back(mk(0, 2'd2, 0, 32'h20, 32'h0,        32'h11AA3344, 0, 2, 0, 32'h0));
      vecs.push_back(mk(1, 2'd2, 0, 32'h30, 32'h80FF7F01, 32'h0,        0, 1, 1, 32'h80FF7F01));
      vecs.push_back(mk(0, 2'd0, 1, 32'h32, 32'h0,        32'hFFFFFFFF, 0, 2, 0, 32'h0));
      vecs.push_back(mk(0, 2'd0, 0, 32'h32, 32'h0,        32'h000000FF, 0, 2, 0, 32'h0));
      vecs.push_back(mk(0, 2'd1, 1, 32'h32, 32'h0,        32'hFFFF80FF, 0, 2, 0, 32'h0));
      vecs.push_back(mk(0, 2'd1, 0, 32'h30, 32'h0,        32'h00007F01, 0, 2, 0, 32'h0));
      vecs.push_back(mk(1, 2'd2, 0, 32'h40, 32'hCAFE1234, 32'h0,        0, 1, 1, 32'hCAFE1234));
      vecs.push_back(mk(1, 2'd1, 0, 32'h42, 32'h00005678, 32'h0,        0, 2, 1, 32'h56781234));
      vecs.push_back(mk(0, 2'd3, 1, 32'h40, 32'h0,        32'h56781234, 0, 2, 0, 32'h0));
`ifdef MEM_ACCESS_ERR_EN
      vecs.push_back(mk(0, 2'd1, 0, 32'h41,   32'h0,      32'h0,        1, 1, 0, 32'h0));
      vecs.push_back(mk(1, 2'd2, 0, 32'h1000, 32'h12345678, 32'h0,      1, 1, 0, 32'h0));
`else
      vecs.push_back(mk(0, 2'd1, 0, 32'h41,   32'h0,      32'h00001234, 0, 2, 0, 32'h0));
`endif

      foreach (vecs[i]) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
         if (vecs[i].wr && !ref_reject(vecs[i].size, vecs[i].addr))
            ref_store(vecs[i].size, vecs[i].addr, vecs[i].wdata);
      end

      // Reset in the write cycle of a byte store: the write must be lost.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'h22; req_wdata = 32'h00000055;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #2 check("rst st_wr write_en_high", 32'(mem_write_en), 32'd1);
      reset = 1'b0;
      #1;
      check("rst write_en_drop", 32'(mem_write_en), 32'd0);
      check("rst resp_valid", 32'(resp_valid), 32'd0);
      check("rst req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk) reset = 1'b1;
      run_txn(mk(0, 2'd2, 0, 32'h20, 32'h0, 32'h11AA3344, 0, 2, 0, 32'h0), "rst word_unchanged");

      // req_valid held across a load then a store.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h10;
      @(posedge clk);
      #1 req_write = 1'b1; req_addr = 32'h50; req_wdata = 32'h12345678;
      @(negedge clk);
      check("b2b ld_rd ready", 32'(req_ready), 32'd0);
      check("b2b ld_rd write_en", 32'(mem_write_en), 32'd0);
      @(negedge clk);
      check("b2b ld_resp ready", 32'(req_ready), 32'd0);
      check("b2b ld_resp valid", 32'(resp_valid), 32'd1);
      check("b2b ld_resp rdata", resp_rdata, 32'hDEADBEEF);
      @(negedge clk);
      check("b2b idle ready", 32'(req_ready), 32'd1);
      check("b2b idle write_en", 32'(mem_write_en), 32'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("b2b st_wr write_en", 32'(mem_write_en), 32'd1);
      check("b2b st_wr addr", mem_write_addr, 32'h50);
      check("b2b st_wr data", mem_write_data, 32'h12345678);
      check("b2b st_wr resp", 32'(resp_valid), 32'd1);
      ref_store(2'd2, 32'h50, 32'h12345678);

      for (int i = 0; i < 300; i++) begin
         rv.wr    = 1'($urandom_range(0, 1));
         rv.size  = 2'($urandom_range(0, 3));
         rv.sgn   = 1'($urandom_range(0, 1));
         rv.addr  = ($urandom_range(0, 9) == 0) ? $urandom_range(4088, 4095) : $urandom_range(0, 255);
         rv.wdata = $urandom;
         rv.exp_rdata = 32'h0; rv.exp_wcnt = 0; rv.exp_wdat = 32'h0; rv.exp_err = 1'b0;
         if (ref_reject(rv.size, rv.addr)) begin
            rv.exp_err = 1'b1; rv.exp_lat = 1;
         end else if (rv.wr) begin
            rv.exp_lat = (rv.size >= 2) ? 1 : 2;
            rv.exp_wcnt = 1;
            ref_store(rv.size, rv.addr, rv.wdata);
            rv.exp_wdat = ref_load(2'd2, 1'b0, {rv.addr[31:2], 2'b00});
         end else begin
            rv.exp_lat = 2;
            rv.exp_rdata = ref_load(rv.size, rv.sgn, rv.addr);
         end
         run_txn(rv, $sformatf("rand%0d", i));
      end

      check("no_rw_overlap", 32'(overlap), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1);
   end

endmodule
